// File: rtl/tsn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tsn_pkg : word-flag constants, bus width and FSM state type shared by     |
// |           the TSN output scheduler.                          rev 1.0      |
// +--------------------------------------------------------------------------+
package tsn_pkg;

   localparam int PKT_W = 134;

   localparam logic [1:0] FLAG_HEAD = 2'b01;
   localparam logic [1:0] FLAG_MID  = 2'b11;
   localparam logic [1:0] FLAG_TAIL = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND0 = 2'd1,
      ST_SEND1 = 2'd2
   } state_t;

   function automatic logic is_tail(input logic [PKT_W-1:0] i_word);
      return i_word[PKT_W-1 -: 2] == FLAG_TAIL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tsn_out_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tsn_src_if / tsn_pkt_if : show-ahead packet source port and packet output |
// |                           port of the TSN output scheduler.   rev 1.0     |
// +--------------------------------------------------------------------------+
interface tsn_src_if;
   logic [tsn_pkg::PKT_W-1:0] data_q;
   logic                      data_rdreq;
   logic                      valid_empty;
   logic                      valid_rdreq;

   modport master (input data_q, valid_empty, output data_rdreq, valid_rdreq);
   modport slave  (output data_q, valid_empty, input data_rdreq, valid_rdreq);
endinterface

interface tsn_pkt_if #(
   parameter int unsigned USEDW_W = 8
);
   logic [tsn_pkg::PKT_W-1:0] data;
   logic                      data_wr;
   logic                      valid;
   logic                      valid_wr;
   logic [USEDW_W-1:0]        usedw;

   modport master (output data, data_wr, valid, valid_wr, input usedw);
   modport slave  (input data, data_wr, valid, valid_wr, output usedw);
endinterface
`default_nettype wire

// File: rtl/tsn_gate_phase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tsn_gate_phase : time-tick detection, gate-cycle phase counter and the    |
// |                  src1 gate decode (TS window + guard band).    rev 1.0    |
// +--------------------------------------------------------------------------+
module tsn_gate_phase #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned GUARD_T = 20
)(
   input  wire                clk,
   input  wire                rst_n,
   input  wire  [47:0]        i_time,
   input  wire  [PHASE_W-1:0] i_period,
   input  wire  [PHASE_W-1:0] i_ts_len,
   output logic               o_be_ok
);

   localparam logic [PHASE_W:0]   c_one_x = (PHASE_W+1)'(1);
   localparam logic [PHASE_W-1:0] c_one   = PHASE_W'(1);

   logic [47:0]        r_prev_time;
   logic [PHASE_W-1:0] r_phase;
   logic               w_tick;
   logic               w_wrap;
   logic               w_ts_win;
   logic [PHASE_W:0]   w_phase_x;
   logic [PHASE_W:0]   w_period_x;
   logic [PHASE_W:0]   w_ts_len_x;
   logic [PHASE_W:0]   w_guard_end;

   // One extra bit keeps phase+GUARD_T and period-1 free of wrap-around.
   assign w_phase_x   = {1'b0, r_phase};
   assign w_period_x  = {1'b0, i_period};
   assign w_ts_len_x  = {1'b0, i_ts_len};
   assign w_guard_end = w_phase_x + (PHASE_W+1)'(GUARD_T);

   assign w_tick   = (i_time != r_prev_time);
   assign w_wrap   = (w_phase_x >= (w_period_x - c_one_x));
   assign w_ts_win = (i_period != '0) && (w_phase_x < w_ts_len_x);
   assign o_be_ok  = !w_ts_win && ((i_period == '0) || (w_guard_end < w_period_x));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_time <= '0;
         r_phase     <= '0;
      end else begin
         r_prev_time <= i_time;
         if (i_period == '0)
            r_phase <= '0;
         else if (w_tick)
            r_phase <= w_wrap ? '0 : (r_phase + c_one);
      end
   end

endmodule
`default_nettype wire

// File: rtl/tsn_out_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tsn_out_sched : strict-priority, time-gated arbiter of two packet FIFOs   |
// |                 onto one output bus. Option: SCHED_STAT_EN.   rev 1.0     |
// +--------------------------------------------------------------------------+
module tsn_out_sched
   import tsn_pkg::*;
#(
   parameter int unsigned USEDW_W      = 8,
   parameter int unsigned USEDW_THRESH = 160,
   parameter int unsigned GUARD_T      = 20,
   parameter int unsigned PHASE_W      = 32
)(
   input  wire                clk,
   input  wire                rst_n,
   input  wire  [47:0]        precision_time,
   input  wire  [PHASE_W-1:0] cfg_period,
   input  wire  [PHASE_W-1:0] cfg_ts_len,
   tsn_src_if.master          src0,
   tsn_src_if.master          src1,
   tsn_pkt_if.master          pktout
`ifdef SCHED_STAT_EN
   ,
   output logic [31:0]        stat_pkt0,
   output logic [31:0]        stat_pkt1,
   output logic [31:0]        stat_block1
`endif
);

   state_t             r_state;
   logic [PKT_W-1:0]   r_data;
   logic               r_wr;
   logic               r_valid;
   logic               r_valid_wr;

   logic [USEDW_W-1:0] w_usedw;
   logic [PKT_W-1:0]   w_q;
   logic               w_be_ok;
   logic               w_room;
   logic               w_req0;
   logic               w_req1;
   logic               w_send0;
   logic               w_send1;
   logic               w_tail;

   tsn_gate_phase #(
      .PHASE_W (PHASE_W),
      .GUARD_T (GUARD_T)
   ) u_gate (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_time   (precision_time),
      .i_period (cfg_period),
      .i_ts_len (cfg_ts_len),
      .o_be_ok  (w_be_ok)
   );

   // Room and gates are only consulted at packet start; a packet is never cut.
   assign w_usedw = pktout.usedw;
   assign w_room  = (32'(w_usedw) <= USEDW_THRESH);
   assign w_req0  = !src0.valid_empty && w_room;
   assign w_req1  = !src1.valid_empty && w_room && w_be_ok;

   assign w_send0 = (r_state == ST_SEND0);
   assign w_send1 = (r_state == ST_SEND1);
   assign w_q     = w_send1 ? src1.data_q : src0.data_q;
   assign w_tail  = is_tail(w_q);

   assign src0.data_rdreq  = w_send0;
   assign src0.valid_rdreq = w_send0 && w_tail;
   assign src1.data_rdreq  = w_send1;
   assign src1.valid_rdreq = w_send1 && w_tail;

   assign pktout.data     = r_data;
   assign pktout.data_wr  = r_wr;
   assign pktout.valid    = r_valid;
   assign pktout.valid_wr = r_valid_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_data     <= '0;
         r_wr       <= 1'b0;
         r_valid    <= 1'b0;
         r_valid_wr <= 1'b0;
      end else begin
         r_wr       <= 1'b0;
         r_valid    <= 1'b0;
         r_valid_wr <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_req0)
                  r_state <= ST_SEND0;
               else if (w_req1)
                  r_state <= ST_SEND1;
            end
            ST_SEND0, ST_SEND1: begin
               r_data <= w_q;
               r_wr   <= 1'b1;
               if (w_tail) begin
                  r_valid    <= 1'b1;
                  r_valid_wr <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SCHED_STAT_EN
   logic [31:0] r_stat_pkt0;
   logic [31:0] r_stat_pkt1;
   logic [31:0] r_stat_block1;
   logic        w_block1;

   assign w_block1 = (r_state == ST_IDLE) && !src1.valid_empty && !w_be_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_pkt0   <= '0;
         r_stat_pkt1   <= '0;
         r_stat_block1 <= '0;
      end else begin
         if (src0.valid_rdreq && (r_stat_pkt0 != '1))
            r_stat_pkt0 <= r_stat_pkt0 + 32'd1;
         if (src1.valid_rdreq && (r_stat_pkt1 != '1))
            r_stat_pkt1 <= r_stat_pkt1 + 32'd1;
         if (w_block1 && (r_stat_block1 != '1))
            r_stat_block1 <= r_stat_block1 + 32'd1;
      end
   end

   assign stat_pkt0   = r_stat_pkt0;
   assign stat_pkt1   = r_stat_pkt1;
   assign stat_block1 = r_stat_block1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tsn_out_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tsn_out_sched : random traffic against a packet-level model of the     |
// |                    scheduler's grant rules and output timing.  rev 1.0    |
// +--------------------------------------------------------------------------+
module tb_tsn_out_sched;
   import tsn_pkg::*;

   localparam int GUARD  = 20;
   localparam int THRESH = 160;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] precision_time;
   logic [31:0] cfg_period;
   logic [31:0] cfg_ts_len;

   always #5 clk = ~clk;

   tsn_src_if                  u_src0 ();
   tsn_src_if                  u_src1 ();
   tsn_pkt_if #(.USEDW_W(8))   u_pkt  ();

   tsn_out_sched #(
      .USEDW_W      (8),
      .USEDW_THRESH (THRESH),
      .GUARD_T      (GUARD),
      .PHASE_W      (32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .precision_time (precision_time),
      .cfg_period     (cfg_period),
      .cfg_ts_len     (cfg_ts_len),
      .src0           (u_src0),
      .src1           (u_src1),
      .pktout         (u_pkt)
   );

   // Source FIFO contents as seen by the DUT.
   logic [133:0] fq0[$], fq1[$];
   int           fd0, fd1;
   // Model copy of pending packets.
   logic [133:0] mw0[$], mw1[$];
   int           ml0[$], ml1[$];
   // Expected output words keyed by cycle.
   logic [133:0] exp_data[int];
   bit           exp_vwr[int];

   int          cyc, free_at, n_ticks;
   int          s_src, s_lo, s_hi;
   int          grants0, grants1, pops0, pops1;
   logic [47:0] last_time;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_val(input string tag, input logic [133:0] got, input logic [133:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic refresh();
      u_src0.data_q      = (fq0.size() != 0) ? fq0[0] : '0;
      u_src1.data_q      = (fq1.size() != 0) ? fq1[0] : '0;
      u_src0.valid_empty = (fd0 == 0);
      u_src1.valid_empty = (fd1 == 0);
   endtask

   task automatic push_pkt(input int src);
      int           len;
      logic [133:0] w;
      len = $urandom_range(2, 7);
      for (int i = 0; i < len; i++) begin
         w[131:0]   = {4'(src), $urandom, $urandom, $urandom, $urandom};
         w[133:132] = (i == 0) ? FLAG_HEAD : ((i == len - 1) ? FLAG_TAIL : FLAG_MID);
         if (src == 0) begin fq0.push_back(w); mw0.push_back(w); end
         else          begin fq1.push_back(w); mw1.push_back(w); end
      end
      if (src == 0) begin ml0.push_back(len); fd0++; end
      else          begin ml1.push_back(len); fd1++; end
   endtask

   // Granted at cycle cyc: SEND occupies cyc+1..cyc+len, words appear two cycles after the grant.
   task automatic grant(input int src);
      int           len;
      logic [133:0] w;
      len = (src == 0) ? ml0.pop_front() : ml1.pop_front();
      for (int i = 0; i < len; i++) begin
         w = (src == 0) ? mw0.pop_front() : mw1.pop_front();
         exp_data[cyc + 2 + i] = w;
         exp_vwr[cyc + 2 + i]  = (i == len - 1);
      end
      s_src   = src;
      s_lo    = cyc + 1;
      s_hi    = cyc + len;
      free_at = cyc + len + 1;
      if (src == 0) grants0++; else grants1++;
   endtask

   // time_mode: 0 = tick every third cycle on average, 1 = every cycle, 2 = every other.
   task automatic step(input int push_pct, input int time_mode, input bit low_usedw);
      bit e_wr, e_vwr, rd0, rd1, vr0, vr1, room, ts_win, be_ok;
      int ph, usedw, r;
      @(negedge clk);
      cyc++;
      e_wr  = exp_data.exists(cyc);
      e_vwr = e_wr && exp_vwr[cyc];
      check_val("data_wr", u_pkt.data_wr, e_wr);
      check_val("valid_wr", u_pkt.valid_wr, e_vwr);
      check_val("valid", u_pkt.valid, e_vwr);
      if (e_wr) begin
         check_val("data", u_pkt.data, exp_data[cyc]);
         exp_data.delete(cyc);
         exp_vwr.delete(cyc);
      end

      if ($urandom_range(0, 99) < push_pct && ml0.size() < 4) push_pkt(0);
      if ($urandom_range(0, 99) < push_pct && ml1.size() < 4) push_pkt(1);
      r = $urandom_range(0, 99);
      if (low_usedw)    usedw = 0;
      else if (r < 70)  usedw = $urandom_range(0, THRESH);
      else if (r < 80)  usedw = THRESH + (r % 2);
      else              usedw = $urandom_range(THRESH + 1, 255);
      u_pkt.usedw = 8'(usedw);
      if (time_mode == 1 || (time_mode == 0 && $urandom_range(0, 2) == 0) ||
          (time_mode == 2 && $urandom_range(0, 1) == 0))
         precision_time = precision_time + (($urandom_range(0, 3) == 0) ? 48'd2 : 48'd1);
      refresh();
      #1;
      rd0 = u_src0.data_rdreq;  vr0 = u_src0.valid_rdreq;
      rd1 = u_src1.data_rdreq;  vr1 = u_src1.valid_rdreq;
      check_val("rdreq0", rd0, s_src == 0 && cyc >= s_lo && cyc <= s_hi);
      check_val("rdreq1", rd1, s_src == 1 && cyc >= s_lo && cyc <= s_hi);
      check_val("vrdreq0", vr0, s_src == 0 && cyc == s_hi);
      check_val("vrdreq1", vr1, s_src == 1 && cyc == s_hi);

      ph = (cfg_period == 0) ? 0 : (n_ticks % int'(cfg_period));
      if (cyc >= free_at) begin
         room   = (usedw <= THRESH);
         ts_win = (cfg_period != 0) && (ph < int'(cfg_ts_len));
         be_ok  = !ts_win && (cfg_period == 0 || ph + GUARD < int'(cfg_period));
         if (ml0.size() != 0 && room)               grant(0);
         else if (ml1.size() != 0 && room && be_ok) grant(1);
      end
      if (precision_time != last_time) n_ticks++;
      last_time = precision_time;

      @(posedge clk);
      #1;
      if (rd0 && fq0.size() != 0) void'(fq0.pop_front());
      if (rd1 && fq1.size() != 0) void'(fq1.pop_front());
      if (vr0) begin fd0--; pops0++; end
      if (vr1) begin fd1--; pops1++; end
      refresh();
   endtask

   task automatic do_reset(input int period, input int ts_len);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("rst_data", u_pkt.data, '0);
      check_val("rst_data_wr", u_pkt.data_wr, 0);
      check_val("rst_valid", u_pkt.valid, 0);
      check_val("rst_valid_wr", u_pkt.valid_wr, 0);
      check_val("rst_rdreq0", u_src0.data_rdreq, 0);
      check_val("rst_rdreq1", u_src1.data_rdreq, 0);
      check_val("rst_vrdreq0", u_src0.valid_rdreq, 0);
      check_val("rst_vrdreq1", u_src1.valid_rdreq, 0);
      cfg_period = 32'(period);
      cfg_ts_len = 32'(ts_len);
      fq0.delete(); fq1.delete(); mw0.delete(); mw1.delete(); ml0.delete(); ml1.delete();
      exp_data.delete(); exp_vwr.delete();
      fd0 = 0; fd1 = 0; cyc = 0; free_at = 0; n_ticks = 0; last_time = '0;
      s_src = -1; s_lo = 0; s_hi = 0;
      grants0 = 0; grants1 = 0; pops0 = 0; pops1 = 0;
      u_pkt.usedw = '0;
      refresh();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic seg_end();
      repeat (300) step(0, 1, 1'b1);
      check_val("left_words0", fq0.size(), mw0.size());
      check_val("left_words1", fq1.size(), mw1.size());
      check_val("pkts0", pops0, grants0);
      check_val("pkts1", pops1, grants1);
      check_val("pending_exp", exp_data.num(), 0);
   endtask

   initial begin
      logic [133:0] d;
      bit           found;
      int           p;
      precision_time = 48'd7;
      cfg_period     = '0;
      cfg_ts_len     = '0;
      u_pkt.usedw    = '0;
      fd0 = 0; fd1 = 0;
      refresh();

      // Gating off, reset abandoned mid-packet, then traffic resumes.
      do_reset(0, 0);
      repeat (250) step(10, 2, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         step(10, 2, 1'b0);
         d = u_pkt.data;
         found = u_pkt.data_wr && (d[133:132] == FLAG_MID);
      end
      check_val("midpkt_found", found, 1);
      do_reset(0, 0);
      repeat (150) step(10, 2, 1'b0);
      seg_end();

      do_reset(100, 40);
      repeat (800) step(6, 1, 1'b0);
      seg_end();

      do_reset(100, 40);
      repeat (800) step(6, 0, 1'b0);
      seg_end();

      p = $urandom_range(40, 100);
      do_reset(p, $urandom_range(0, p - GUARD - 1));
      repeat (600) step(8, 2, 1'b0);
      seg_end();

      // TS window covers the whole cycle: src1 must never be granted.
      do_reset(50, 60);
      repeat (300) step(8, 1, 1'b0);
      seg_end();
      check_val("src1_starved", pops1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tsn_out_sched.md
Name: tsn_out_sched

Overview:
Time-aware output scheduler for the user-module egress. It shares one 134-bit packet output bus between two packet sources: src0, the time-sensitive queue, and src1, the best-effort queue. Both sources are show-ahead packet FIFOs (data FIFO plus a per-packet valid FIFO). Gating is 802.1Qbv-style: a phase counter is driven by precision_time, src0 has a protected window, and src1 is subject to a guard band. The block sits between the UM classification/queueing stage and pktout_data_0 toward the MAC side.

Parameters:
USEDW_W, 8, width of the downstream FIFO fill level.
USEDW_THRESH, 160, highest downstream fill level at which a new packet may start.
GUARD_T, 20, guard band in precision_time ticks before the next cycle start; no src1 start inside it.
PHASE_W, 32, width of the phase counter and of the config registers.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
precision_time  in  48  global synchronized time, increments in ticks.
cfg_period  in  PHASE_W  gate cycle length in ticks; 0 = gating off.
cfg_ts_len  in  PHASE_W  src0-exclusive window length; the window is phase 0..cfg_ts_len-1.
src0_data_q  in  134  show-ahead head word; [133:132] = 01 head / 11 middle / 10 tail.
src0_data_rdreq  out  1  pop one src0 data word.
src0_valid_empty  in  1  no complete src0 packet queued.
src0_valid_rdreq  out  1  pop the src0 packet descriptor; asserted on the tail word.
src1_data_q, src1_data_rdreq, src1_valid_empty, src1_valid_rdreq  same as the src0 set, for the best-effort source.
pktout_data  out  134  output word.
pktout_data_wr  out  1  output word strobe.
pktout_valid  out  1  packet-good flag.
pktout_valid_wr  out  1  packet-complete strobe; asserted with the tail word only.
pktout_usedw  in  USEDW_W  downstream FIFO fill level.

Behaviour:
- Reset (asynchronous assertion)
  - All outputs 0, state IDLE, phase 0, prev_time 0.
  - A packet in flight is abandoned; the source FIFOs are reset by the same rst_n.
- Phase counter
  - A tick is registered when precision_time != prev_time.
  - On a tick: phase <= (phase >= cfg_period-1) ? 0 : phase+1.
  - When cfg_period = 0, phase is held at 0.
  - A shrunken period therefore wraps on the next tick.
- Gate decode (combinational, compares done at PHASE_W+1 bits)
  - ts_win = (cfg_period != 0) && (phase < cfg_ts_len).
  - be_ok = !ts_win && (cfg_period == 0 || phase + GUARD_T < cfg_period).
  - cfg_ts_len >= cfg_period means src1 is never granted.
- Start condition
  - room = (pktout_usedw <= USEDW_THRESH).
  - req0 = !src0_valid_empty && room.
  - req1 = !src1_valid_empty && room && be_ok.
  - Strict priority: req0 beats req1, in every window.
- State machine: IDLE, SEND0, SEND1.
  - IDLE: if req0, go to SEND0; else if req1, go to SEND1; else stay in IDLE.
  - SENDn: assert srcN_data_rdreq every cycle.
  - SENDn output register, next cycle: pktout_data <= srcN_data_q and pktout_data_wr <= 1.
  - SENDn tail word (flag 10): also assert srcN_valid_rdreq; pktout_valid_wr and pktout_valid are 1 on the same output cycle as the tail; return to IDLE.
- Latency and timing
  - The first output word appears 2 cycles after the req is seen in IDLE.
  - There is 1 idle output cycle minimum between packets.
- Packet handling rules
  - A packet is never stalled or pre-empted mid-transfer; room and the gates are checked at the start only.
  - A gate closing mid-packet does not cut the packet.
  - Framing is the source's guarantee: the head flag is not checked, and only the 10 flag ends a transfer.
- Simultaneous events
  - A tick during a transfer only advances the phase.
  - When both sources are ready, src0 is granted.

Optional Feature:
Macro SCHED_STAT_EN.
- Defined: adds the outputs stat_pkt0 [31:0], stat_pkt1 [31:0] and stat_block1 [31:0].
  - stat_pkt0 / stat_pkt1 increment on each srcN_valid_rdreq.
  - stat_block1 increments once per cycle in IDLE where src1 has a packet but be_ok = 0.
  - All three saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; the datapath is identical.

Decomposition:
- Shared package tsn_pkg:
  - flag constants FLAG_HEAD = 2'b01, FLAG_MID = 2'b11, FLAG_TAIL = 2'b10.
  - PKT_W = 134.
  - the state enum.
- One sub-module, tsn_gate_phase: prev_time/tick detect, phase counter, ts_win/be_ok decode.
- The arbiter FSM and output register stay in the top level.

Test Plan:
1. cfg_period=0; 6-word src0 packet (01,11,11,11,11,10) -> 6 contiguous pktout_data_wr words, first at +2 cycles; pktout_valid_wr=pktout_valid=1 only on the 10 word; src0_valid_rdreq pulses once.
2. cfg_period=0; src0 and src1 packets pending together -> full src0 packet, 1 idle cycle, then the full src1 packet.
3. cfg_period=100, cfg_ts_len=40; src1 pending at phase 10 -> no output until phase 40; src1 packet starts in the cycle after phase reaches 40.
4. GUARD_T=20, period 100, ts_len 40; src1 pending at phase 85 -> not started (85+20 ≥ 100); starts at phase 40 of the next cycle. src0 pending at phase 85 -> starts immediately.
5. pktout_usedw=200 with src0 pending -> no start; pktout_usedw drops to 100 -> packet starts 2 cycles later. A usedw rise to 250 mid-packet -> no stall.
6. rst_n pulsed low during the 3rd word of a packet -> all outputs 0 within the same cycle, state IDLE; after release with a new packet queued -> normal 2-cycle start.
